serdesphy_link_sequencer: RTL and testbench

//   Power-up and recovery sequencer for the PHY clock manager. On a CSR link

---
 rtl/serdesphy_link_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_serdesphy_link_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serdesphy_link_sequencer.sv
// -----------------------------------------------------------------------------
// serdesphy_link_sequencer
//   Power-up and recovery sequencer for the PHY clock manager. A CSR link
//   enable walks the PHY through enable, PLL reset release and CDR reset
//   release. It waits for PLL lock and then CDR lock, each wait bounded by a
//   timeout. Timeouts and loss of lock cause bounded retries; once the retries
//   are used up the sequencer parks in FAIL until the link enable is dropped.
//
// Ports
//   clk_ref_24m    in   1        24 MHz reference clock
//   rst_n          in   1        async active-low reset
//   i_link_en      in   1        CSR level: 1 = bring link up, 0 = shut down
//   i_pll_lock     in   1        PLL lock from clock manager
//   i_cdr_lock     in   1        CDR lock from clock manager
//   o_phy_en       out  1        PHY global enable
//   o_pll_rst      out  1        PLL reset
//   o_cdr_rst      out  1        CDR reset
//   o_link_up      out  1        1 while in LINK_UP
//   o_fail         out  1        1 while in FAIL
//   o_lock_lost    out  1        1-cycle pulse when lock drops in LINK_UP
//   o_state        out  3        encoded FSM state (CSR readback)
//   o_retry_cnt    out  RETRY_W  retries used in the current attempt
// -----------------------------------------------------------------------------
module serdesphy_link_sequencer #(
    parameter int unsigned RST_CYCLES  = 8,
    parameter int unsigned PLL_TIMEOUT = 512,
    parameter int unsigned CDR_TIMEOUT = 256,
    parameter int unsigned CNT_W       = 10,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned RETRY_W     = 2
) (
    input  logic               clk_ref_24m,
    input  logic               rst_n,
    input  logic               i_link_en,
    input  logic               i_pll_lock,
    input  logic               i_cdr_lock,
    output logic               o_phy_en,
    output logic               o_pll_rst,
    output logic               o_cdr_rst,
    output logic               o_link_up,
    output logic               o_fail,
    output logic               o_lock_lost,
    output logic [2:0]         o_state,
    output logic [RETRY_W-1:0] o_retry_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RESET    = 3'd1,
        ST_PLL_WAIT = 3'd2,
        ST_CDR_WAIT = 3'd3,
        ST_LINK_UP  = 3'd4,
        ST_FAIL     = 3'd5
    } state_t;

    // Last timer value of each timed state: the exit happens on the next edge.
    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   PLL_LAST  = CNT_W'(PLL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CDR_LAST  = CNT_W'(CDR_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_timer;
    logic [RETRY_W-1:0]   r_retry_cnt;
    logic [RETRY_W-1:0]   w_retry_nxt;
    logic                 w_retry;
    logic                 w_lock_lost_nxt;

    logic                 r_phy_en;
    logic                 r_pll_rst;
    logic                 r_cdr_rst;
    logic                 r_link_up;
    logic                 r_fail;
    logic                 r_lock_lost;
    logic                 w_phy_en_nxt;
    logic                 w_pll_rst_nxt;
    logic                 w_cdr_rst_nxt;
    logic                 w_link_up_nxt;
    logic                 w_fail_nxt;

    // State register, timer, retry counter and registered outputs.
    always_ff @(posedge clk_ref_24m or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_retry_cnt <= '0;
            r_phy_en    <= 1'b0;
            r_pll_rst   <= 1'b1;
            r_cdr_rst   <= 1'b1;
            r_link_up   <= 1'b0;
            r_fail      <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_retry_cnt <= w_retry_nxt;
            r_phy_en    <= w_phy_en_nxt;
            r_pll_rst   <= w_pll_rst_nxt;
            r_cdr_rst   <= w_cdr_rst_nxt;
            r_link_up   <= w_link_up_nxt;
            r_fail      <= w_fail_nxt;
            r_lock_lost <= w_lock_lost_nxt;
            if (w_state_nxt != r_state) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + CNT_W'(1);
            end
        end
    end

    // Next-state, retry bookkeeping and output decode of the next state.
    always_comb begin
        w_state_nxt     = r_state;
        w_retry_nxt     = r_retry_cnt;
        w_retry         = 1'b0;
        w_lock_lost_nxt = 1'b0;
        w_phy_en_nxt    = 1'b0;
        w_pll_rst_nxt   = 1'b1;
        w_cdr_rst_nxt   = 1'b1;
        w_link_up_nxt   = 1'b0;
        w_fail_nxt      = 1'b0;

        if (!i_link_en) begin
            w_state_nxt = ST_IDLE;
            w_retry_nxt = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_RESET;
                end
                ST_RESET: begin
                    if (r_timer == RST_LAST) begin
                        w_state_nxt = ST_PLL_WAIT;
                    end
                end
                ST_PLL_WAIT: begin
                    // Lock is checked before the timeout so a same-cycle lock wins.
                    if (i_pll_lock) begin
                        w_state_nxt = ST_CDR_WAIT;
                    end else if (r_timer == PLL_LAST) begin
                        w_retry = 1'b1;
                    end
                end
                ST_CDR_WAIT: begin
                    if (!i_pll_lock) begin
                        w_retry = 1'b1;
                    end else if (i_cdr_lock) begin
                        w_state_nxt = ST_LINK_UP;
                    end else if (r_timer == CDR_LAST) begin
                        w_retry = 1'b1;
                    end
                end
                ST_LINK_UP: begin
                    if (!i_pll_lock || !i_cdr_lock) begin
                        w_lock_lost_nxt = 1'b1;
                        w_retry         = 1'b1;
                    end
                end
                ST_FAIL: begin
                    w_state_nxt = ST_FAIL;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            if (w_retry) begin
                if (r_retry_cnt < RETRY_MAX) begin
                    w_retry_nxt = r_retry_cnt + RETRY_W'(1);
                    w_state_nxt = ST_RESET;
                end else begin
                    w_state_nxt = ST_FAIL;
                end
            end

            // A successful bring-up starts a fresh retry budget.
            if ((w_state_nxt == ST_LINK_UP) && (r_state != ST_LINK_UP)) begin
                w_retry_nxt = '0;
            end
        end

        unique case (w_state_nxt)
            ST_IDLE: begin
                w_phy_en_nxt  = 1'b0;
                w_pll_rst_nxt = 1'b1;
                w_cdr_rst_nxt = 1'b1;
            end
            ST_RESET: begin
                w_phy_en_nxt  = 1'b1;
                w_pll_rst_nxt = 1'b1;
                w_cdr_rst_nxt = 1'b1;
            end
            ST_PLL_WAIT: begin
                w_phy_en_nxt  = 1'b1;
                w_pll_rst_nxt = 1'b0;
                w_cdr_rst_nxt = 1'b1;
            end
            ST_CDR_WAIT: begin
                w_phy_en_nxt  = 1'b1;
                w_pll_rst_nxt = 1'b0;
                w_cdr_rst_nxt = 1'b0;
            end
            ST_LINK_UP: begin
                w_phy_en_nxt  = 1'b1;
                w_pll_rst_nxt = 1'b0;
                w_cdr_rst_nxt = 1'b0;
                w_link_up_nxt = 1'b1;
            end
            ST_FAIL: begin
                w_phy_en_nxt  = 1'b0;
                w_pll_rst_nxt = 1'b1;
                w_cdr_rst_nxt = 1'b1;
                w_fail_nxt    = 1'b1;
            end
            default: begin
                w_phy_en_nxt  = 1'b0;
                w_pll_rst_nxt = 1'b1;
                w_cdr_rst_nxt = 1'b1;
            end
        endcase
    end

    assign o_phy_en    = r_phy_en;
    assign o_pll_rst   = r_pll_rst;
    assign o_cdr_rst   = r_cdr_rst;
    assign o_link_up   = r_link_up;
    assign o_fail      = r_fail;
    assign o_lock_lost = r_lock_lost;
    assign o_state     = r_state;
    assign o_retry_cnt = r_retry_cnt;

endmodule

// File: tb/tb_serdesphy_link_sequencer.sv
// -----------------------------------------------------------------------------
// tb_serdesphy_link_sequencer
//   Directed bench for the link sequencer. Inputs change 1 time unit after the
//   rising edge; outputs are sampled at the same point, after the edge that
//   acted on the previous inputs. Expected output vectors come from the state
//   decode table of the design.
// -----------------------------------------------------------------------------
module tb_serdesphy_link_sequencer;

    logic       clk_ref_24m;
    logic       rst_n;
    logic       link_en;
    logic       pll_lock;
    logic       cdr_lock;
    logic       phy_en;
    logic       pll_rst;
    logic       cdr_rst;
    logic       link_up;
    logic       fail;
    logic       lock_lost;
    logic [2:0] state;
    logic [1:0] retry_cnt;

    int n_vec = 0;
    int n_bad = 0;

    serdesphy_link_sequencer dut (
        .clk_ref_24m (clk_ref_24m),
        .rst_n       (rst_n),
        .i_link_en   (link_en),
        .i_pll_lock  (pll_lock),
        .i_cdr_lock  (cdr_lock),
        .o_phy_en    (phy_en),
        .o_pll_rst   (pll_rst),
        .o_cdr_rst   (cdr_rst),
        .o_link_up   (link_up),
        .o_fail      (fail),
        .o_lock_lost (lock_lost),
        .o_state     (state),
        .o_retry_cnt (retry_cnt)
    );

    initial clk_ref_24m = 1'b0;
    always #5 clk_ref_24m = ~clk_ref_24m;

    // Packed view {state, phy_en, pll_rst, cdr_rst, link_up, fail, lock_lost, retry_cnt}.
    function automatic logic [10:0] expect_vec(input int st, input bit lost, input int rt);
        logic [2:0] d;
        case (st)
            0:       d = 3'b011;
            1:       d = 3'b111;
            2:       d = 3'b101;
            3:       d = 3'b100;
            4:       d = 3'b100;
            5:       d = 3'b011;
            default: d = 3'b000;
        endcase
        return {3'(st), d, (st == 4), (st == 5), lost, 2'(rt)};
    endfunction

    task automatic chk(input string tag, input int st, input bit lost, input int rt);
        logic [10:0] obs;
        logic [10:0] exp;
        obs = {state, phy_en, pll_rst, cdr_rst, link_up, fail, lock_lost, retry_cnt};
        exp = expect_vec(st, lost, rt);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_ref_24m);
            #1;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        link_en  = 1'b0;
        pll_lock = 1'b0;
        cdr_lock = 1'b0;
        #12;
        chk("reset_values", 0, 0, 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("idle_after_reset", 0, 0, 0);

        // Nominal bring-up.
        link_en = 1'b1;
        tick(1);
        chk("nom_reset_entry", 1, 0, 0);
        tick(7);
        chk("nom_reset_last", 1, 0, 0);
        tick(1);
        chk("nom_pll_wait", 2, 0, 0);
        tick(100);
        chk("nom_pll_wait_t100", 2, 0, 0);
        pll_lock = 1'b1;
        tick(1);
        chk("nom_cdr_wait", 3, 0, 0);
        tick(49);
        chk("nom_cdr_wait_hold", 3, 0, 0);
        cdr_lock = 1'b1;
        tick(1);
        chk("nom_link_up", 4, 0, 0);

        // Loss of lock: one-cycle CDR drop.
        cdr_lock = 1'b0;
        tick(1);
        chk("lol_pulse", 1, 1, 1);
        cdr_lock = 1'b1;
        tick(1);
        chk("lol_pulse_gone", 1, 0, 1);
        tick(6);
        chk("lol_reset_last", 1, 0, 1);
        tick(1);
        chk("lol_pll_wait", 2, 0, 1);
        tick(1);
        chk("lol_cdr_wait", 3, 0, 1);
        tick(1);
        chk("lol_relink_clears_retry", 4, 0, 0);

        // Shutdown in the middle of PLL_WAIT.
        link_en  = 1'b0;
        pll_lock = 1'b0;
        cdr_lock = 1'b0;
        tick(1);
        chk("off_from_link_up", 0, 0, 0);
        link_en = 1'b1;
        tick(9);
        tick(37);
        chk("off_pll_wait_t37", 2, 0, 0);
        link_en = 1'b0;
        tick(1);
        chk("off_to_idle", 0, 0, 0);

        // Lock arriving on the timeout cycle wins.
        link_en = 1'b1;
        tick(9);
        tick(511);
        chk("race_pll_t511", 2, 0, 0);
        pll_lock = 1'b1;
        tick(1);
        chk("race_lock_wins", 3, 0, 0);

        // CDR timeout, then PLL lock dropping while waiting for CDR.
        tick(255);
        chk("cdr_t255", 3, 0, 0);
        tick(1);
        chk("cdr_timeout_retry", 1, 0, 1);
        tick(8);
        chk("cdr_retry_pll_wait", 2, 0, 1);
        tick(1);
        chk("cdr_retry_cdr_wait", 3, 0, 1);
        pll_lock = 1'b0;
        tick(1);
        chk("cdr_pll_drop_retry", 1, 0, 2);

        // Async reset between edges in CDR_WAIT.
        pll_lock = 1'b1;
        tick(8);
        tick(1);
        tick(5);
        chk("ar_in_cdr_wait", 3, 0, 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_immediate", 0, 0, 0);
        link_en = 1'b0;
        #2;
        rst_n = 1'b1;
        tick(1);
        chk("ar_released", 0, 0, 0);

        // PLL never locks: three retries, then FAIL.
        pll_lock = 1'b0;
        cdr_lock = 1'b0;
        link_en  = 1'b1;
        tick(1);
        chk("to_start", 1, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            tick(519);
            chk($sformatf("to_att%0d_last", k), 2, 0, k - 1);
            tick(1);
            chk($sformatf("to_att%0d_retry", k), 1, 0, k);
        end
        tick(519);
        chk("to_att4_last", 2, 0, 3);
        tick(1);
        chk("to_fail", 5, 0, 3);
        pll_lock = 1'b1;
        cdr_lock = 1'b1;
        tick(3);
        chk("to_fail_sticky", 5, 0, 3);
        link_en = 1'b0;
        tick(1);
        chk("to_fail_cleared", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
